cmd_frame_parser: RTL
=====================

// Module: cmd_frame_parser
// PURPOSE
//  Command-frame decoder directly downstream of the comm-port UART selector. It drains command
//  bytes from the selected comm UART RX FIFO (rec_command/com_count/com_pop) and resyncs on the
//  inter-frame gap (command_time_out_d). It validates each frame, then drives the switch,
//  power-control and debug controls consumed by the core.
//  Each frame is answered with an ACK/NAK pushed into both CPU UART TX FIFOs (tdr_cpuAB/tf_push_cpuAB).
// PARAMETERS
//  HDR0     8'hEB  first frame header byte
//  HDR1     8'h90  second frame header byte
//  ACK_B    8'h5A  leading byte of every reply
//  CNT_W    5      width of com_count; equals UART_FIFO_COUNTER_W
// PORTS
//  clk                    in   1      system clock; sole clock
//  rst                    in   1      synchronous, active-high reset
//  rec_command            in   8      head byte of selected RX FIFO; valid while com_count!=0
//  com_count              in   CNT_W  bytes held in selected RX FIFO
//  command_time_out_d     in   1      high while both comm lines have been idle > MAX_IDLE_T
//  com_pop                out  1      1-cycle pulse: discard head byte of the RX FIFO
//  tdr_cpuAB              out  8      reply byte to CPU UARTs; valid with tf_push_cpuAB
//  tf_push_cpuAB          out  1      1-cycle push strobe to both CPU TX FIFOs
//  cmd_swi                out  1      0: select CPU A, 1: select CPU B
//  force_swi              out  1      1: cmd_swi overrides heartbeat-based switching
//  cmd_power_on_A/_B      out  1 ea   commanded power state of CPU A/B
//  force_power_control_A/_B out 1 ea  1: commanded power state overrides automatic control
//  debug_mode             out  1      debug mode enable
//  error                  out  1      sticky: last frame bad; cleared by next good frame
// BEHAVIOUR
//  Reset: every output 0; parser in S_H0; fetcher idle. Reset mid-frame discards the partial frame.
//  Fetch: two cycles per byte.
//   - Cycle n: fetcher idle, com_count!=0 and parser not in EXEC/ACK -> com_pop=1 and rec_command is captured.
//   - Cycle n+1: byte_vld=1 to the FSM and no pop, which lets com_count settle.
//  Frame: HDR0 HDR1 CMD ARG CHK, where CHK = (CMD+ARG) mod 256.
//  FSM states: S_H0 S_H1 S_CMD S_ARG S_CHK S_EXEC S_ACK0 S_ACK1.
//   - S_H0: byte==HDR0 -> S_H1; any other byte is dropped silently.
//   - S_H1: HDR1 -> S_CMD; HDR0 -> stay in S_H1; any other byte -> S_H0. No error in either case.
//   - S_CMD and S_ARG: latch the byte, then advance.
//   - S_CHK: latch the byte -> S_EXEC.
//  S_EXEC (1 cycle after CHK byte_vld):
//   - Checksum good and CMD known: registers updated, error<=0, status=CMD.
//   - Otherwise: no control change, error<=1, status=8'hFF.
//  CMD decode:
//   - 0x01: cmd_swi<=ARG[0], force_swi<=ARG[1].
//   - 0x02: cmd_power_on_A<=ARG[0], cmd_power_on_B<=ARG[1], force_power_control_A<=ARG[2], force_power_control_B<=ARG[3].
//   - 0x03: debug_mode<=ARG[0].
//   - Any other CMD is unknown.
//  Reply:
//   - S_ACK0 pushes ACK_B; one idle cycle follows.
//   - S_ACK1 pushes status; one idle cycle follows, then S_H0.
//   - tf_push_cpuAB is never high on consecutive cycles. Reply = 4 cycles after EXEC.
//  Timeout:
//   - command_time_out_d=1 in S_CMD/S_ARG/S_CHK -> S_H0, error<=1, no reply.
//   - In S_H1 -> S_H0 with no error. Ignored in S_EXEC/S_ACK*.
//   - Timeout and byte_vld in the same cycle: timeout acts first, then the byte is evaluated as in S_H0.
//  FIFO empty: fetcher idles and parser waits indefinitely (timeout resync only).
//  Bytes arriving during EXEC/ACK stay in the FIFO, i.e. backpressure, never lost.
//  Outputs are registered and hold until the next good frame of the same CMD.
// STRUCTURE
//  Shared package cmd_frame_pkg (localparams): state encodings, CMD codes 0x01-0x03, NAK status 8'hFF.
//  One sub-module, cmd_byte_fetch, holds the pop/valid handshake. The FSM and decode stay in this module.
// TESTING
//  1. Frame EB 90 01 03 04 -> cmd_swi=1, force_swi=1, error=0; pushes 5A then 01, 2 cycles apart.
//  2. Frame EB 90 02 05 07 -> power_on_A=1, power_on_B=0, force_A=1, force_B=0; reply 5A 02.
//  3. Frame EB 90 03 01 00 (bad CHK) -> no output change, error=1; reply 5A FF.
//     Then EB 90 03 01 04 -> debug_mode=1, error=0.
//  4. Frame EB 90 07 00 07 (unknown CMD) -> error=1, reply 5A FF, other outputs unchanged.
//  5. Bytes 12 EB EB 90 01 00 01 -> junk skipped; cmd_swi=0, force_swi=0; one reply 5A 01.
//  6. Frame EB 90 01 then command_time_out_d=1 -> S_H0, error=1, no push.
//     Next EB 90 01 01 02 -> cmd_swi=1.
//     Assert rst mid-frame -> all outputs 0, next cycle com_pop=0.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// Shared constants for the command-frame parser: frame bytes, command codes,
// FSM state encodings and the control-register payload.
package cmd_frame_pkg;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned STATE_W = 3;

    localparam logic [7:0] HDR0       = 8'hEB;
    localparam logic [7:0] HDR1       = 8'h90;
    localparam logic [7:0] ACK_B      = 8'h5A;
    localparam logic [7:0] NAK_STATUS = 8'hFF;

    localparam logic [7:0] CMD_SWI = 8'h01;
    localparam logic [7:0] CMD_PWR = 8'h02;
    localparam logic [7:0] CMD_DBG = 8'h03;

    localparam logic [STATE_W-1:0] S_H0   = 3'd0;
    localparam logic [STATE_W-1:0] S_H1   = 3'd1;
    localparam logic [STATE_W-1:0] S_CMD  = 3'd2;
    localparam logic [STATE_W-1:0] S_ARG  = 3'd3;
    localparam logic [STATE_W-1:0] S_CHK  = 3'd4;
    localparam logic [STATE_W-1:0] S_EXEC = 3'd5;
    localparam logic [STATE_W-1:0] S_ACK0 = 3'd6;
    localparam logic [STATE_W-1:0] S_ACK1 = 3'd7;

    // Control registers driven towards the core
    typedef struct packed {
        logic debug_mode;
        logic force_pwr_b;
        logic force_pwr_a;
        logic pwr_on_b;
        logic pwr_on_a;
        logic force_swi;
        logic cmd_swi;
    } ctrl_t;

    // Frame checksum: CMD + ARG modulo 256
    function automatic logic chk_ok(input logic [7:0] cmd, input logic [7:0] arg,
                                    input logic [7:0] chk);
        return 8'(cmd + arg) == chk;
    endfunction

endpackage

// File: rtl/cmd_frame_parser_cmd_byte_fetch.sv
// Byte fetcher: pops one byte from the comm RX FIFO and presents it to the
// parser one cycle later. Two cycles per byte so com_count can settle.
// Ports: clk, rst (sync, active-high); rec_command/com_count from the FIFO;
//        stall holds the FIFO (parser executing/replying); com_pop to the FIFO;
//        byte_vld/byte_data to the parser.
module cmd_byte_fetch
    import cmd_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rec_command,
    input  logic [CNT_W-1:0] com_count,
    input  logic             stall,
    output logic             com_pop,
    output logic             byte_vld,
    output logic [7:0]       byte_data
);

    // Pop only from idle; the valid cycle that follows is the settle cycle
    assign com_pop = !rst && !byte_vld && (com_count != '0) && !stall;

    // Capture the popped head byte
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_vld  <= 1'b0;
            byte_data <= 8'h00;
        end else begin
            byte_vld <= com_pop;
            if (com_pop) begin
                byte_data <= rec_command;
            end
        end
    end

endmodule

// File: rtl/cmd_frame_parser.sv
// Command-frame parser: validates EB 90 CMD ARG CHK frames drained from the
// comm RX FIFO, updates the switch/power/debug controls and answers each frame
// with a 5A + status reply to both CPU TX FIFOs.
// Ports: clk, rst (sync, active-high); rec_command/com_count/com_pop to the
//        RX FIFO; command_time_out_d inter-frame gap; tdr_cpuAB/tf_push_cpuAB
//        reply push; cmd_swi, force_swi, cmd_power_on_A/B,
//        force_power_control_A/B, debug_mode controls; error sticky status.
module cmd_frame_parser
    import cmd_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rec_command,
    input  logic [CNT_W-1:0] com_count,
    input  logic             command_time_out_d,
    output logic             com_pop,
    output logic [7:0]       tdr_cpuAB,
    output logic             tf_push_cpuAB,
    output logic             cmd_swi,
    output logic             force_swi,
    output logic             cmd_power_on_A,
    output logic             cmd_power_on_B,
    output logic             force_power_control_A,
    output logic             force_power_control_B,
    output logic             debug_mode,
    output logic             error
);

    logic [STATE_W-1:0] state, state_nxt, eff_state;
    logic               gap, gap_nxt;
    logic [7:0]         cmd_q, cmd_nxt, arg_q, arg_nxt, chk_q, chk_nxt;
    logic [7:0]         status_q, status_nxt;
    logic [7:0]         tdr_q, tdr_nxt;
    logic               push_q, push_nxt;
    logic               err_q, err_nxt;
    logic               good;
    ctrl_t              ctrl, ctrl_nxt;
    logic               byte_vld;
    logic [7:0]         byte_data;
    logic               stall;

    // FIFO is held while a frame is executed and answered
    assign stall = (state == S_EXEC) || (state == S_ACK0) || (state == S_ACK1);

    cmd_byte_fetch u_fetch (
        .clk         (clk),
        .rst         (rst),
        .rec_command (rec_command),
        .com_count   (com_count),
        .stall       (stall),
        .com_pop     (com_pop),
        .byte_vld    (byte_vld),
        .byte_data   (byte_data)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_H0;
            gap      <= 1'b0;
            cmd_q    <= 8'h00;
            arg_q    <= 8'h00;
            chk_q    <= 8'h00;
            status_q <= 8'h00;
            tdr_q    <= 8'h00;
            push_q   <= 1'b0;
            err_q    <= 1'b0;
            ctrl     <= '0;
        end else begin
            state    <= state_nxt;
            gap      <= gap_nxt;
            cmd_q    <= cmd_nxt;
            arg_q    <= arg_nxt;
            chk_q    <= chk_nxt;
            status_q <= status_nxt;
            tdr_q    <= tdr_nxt;
            push_q   <= push_nxt;
            err_q    <= err_nxt;
            ctrl     <= ctrl_nxt;
        end
    end

    // Next-state, frame decode and reply sequencing
    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap;
        cmd_nxt    = cmd_q;
        arg_nxt    = arg_q;
        chk_nxt    = chk_q;
        status_nxt = status_q;
        tdr_nxt    = tdr_q;
        push_nxt   = 1'b0;
        err_nxt    = err_q;
        ctrl_nxt   = ctrl;
        good       = 1'b0;
        eff_state  = state;

        // Gap resync comes first; a byte in the same cycle is then seen from S_H0
        if (command_time_out_d && (state >= S_H1) && (state <= S_CHK)) begin
            eff_state = S_H0;
            state_nxt = S_H0;
            if (state != S_H1) begin
                err_nxt = 1'b1;
            end
        end

        case (eff_state)
            S_H0: begin
                if (byte_vld && (byte_data == HDR0)) begin
                    state_nxt = S_H1;
                end
            end
            S_H1: begin
                if (byte_vld) begin
                    if (byte_data == HDR1) begin
                        state_nxt = S_CMD;
                    end else if (byte_data != HDR0) begin
                        state_nxt = S_H0;
                    end
                end
            end
            S_CMD: begin
                if (byte_vld) begin
                    cmd_nxt   = byte_data;
                    state_nxt = S_ARG;
                end
            end
            S_ARG: begin
                if (byte_vld) begin
                    arg_nxt   = byte_data;
                    state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (byte_vld) begin
                    chk_nxt   = byte_data;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (chk_ok(cmd_q, arg_q, chk_q)) begin
                    case (cmd_q)
                        CMD_SWI: begin
                            ctrl_nxt.cmd_swi   = arg_q[0];
                            ctrl_nxt.force_swi = arg_q[1];
                            good               = 1'b1;
                        end
                        CMD_PWR: begin
                            ctrl_nxt.pwr_on_a    = arg_q[0];
                            ctrl_nxt.pwr_on_b    = arg_q[1];
                            ctrl_nxt.force_pwr_a = arg_q[2];
                            ctrl_nxt.force_pwr_b = arg_q[3];
                            good                 = 1'b1;
                        end
                        CMD_DBG: begin
                            ctrl_nxt.debug_mode = arg_q[0];
                            good                = 1'b1;
                        end
                        default: good = 1'b0;
                    endcase
                end
                err_nxt    = !good;
                status_nxt = good ? cmd_q : NAK_STATUS;
                gap_nxt    = 1'b0;
                state_nxt  = S_ACK0;
            end
            // Each reply byte is followed by an idle cycle (gap) so pushes never abut
            S_ACK0: begin
                if (!gap) begin
                    push_nxt = 1'b1;
                    tdr_nxt  = ACK_B;
                    gap_nxt  = 1'b1;
                end else begin
                    gap_nxt   = 1'b0;
                    state_nxt = S_ACK1;
                end
            end
            S_ACK1: begin
                if (!gap) begin
                    push_nxt = 1'b1;
                    tdr_nxt  = status_q;
                    gap_nxt  = 1'b1;
                end else begin
                    gap_nxt   = 1'b0;
                    state_nxt = S_H0;
                end
            end
            default: state_nxt = S_H0;
        endcase
    end

    assign tdr_cpuAB             = tdr_q;
    assign tf_push_cpuAB         = push_q;
    assign cmd_swi               = ctrl.cmd_swi;
    assign force_swi             = ctrl.force_swi;
    assign cmd_power_on_A        = ctrl.pwr_on_a;
    assign cmd_power_on_B        = ctrl.pwr_on_b;
    assign force_power_control_A = ctrl.force_pwr_a;
    assign force_power_control_B = ctrl.force_pwr_b;
    assign debug_mode            = ctrl.debug_mode;
    assign error                 = err_q;

endmodule
